// File: rtl/regfile_sb.sv
// Write-back register file with two combinational read ports, a WB->ID bypass,
// and a per-register in-flight-write scoreboard that supplies hazard busy flags.
module regfile_sb #(
  parameter int REG_NUM      = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int REG_LEN      = 32,
  parameter int CNT_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_rd_enable,
  input  logic [REG_ADDR_LEN-1:0] wb_rd_addr,
  input  logic [REG_LEN-1:0]      wb_rd_data,
  input  logic                    read1_enable,
  input  logic [REG_ADDR_LEN-1:0] read1_addr,
  output logic [REG_LEN-1:0]      read1_data,
  output logic                    read1_busy,
  input  logic                    read2_enable,
  input  logic [REG_ADDR_LEN-1:0] read2_addr,
  output logic [REG_LEN-1:0]      read2_data,
  output logic                    read2_busy,
  input  logic                    issue_enable,
  input  logic [REG_ADDR_LEN-1:0] issue_addr,
  output logic                    sb_overflow,
  output logic                    sb_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [REG_LEN-1:0] regs [REG_NUM];
  logic [CNT_W-1:0]   cnt  [REG_NUM];

  logic ovf_hit;
  logic unf_hit;
  logic ret1;
  logic ret2;

  function automatic logic addr_hit(input logic en,
                                    input logic [REG_ADDR_LEN-1:0] a,
                                    input int i);
    return en && (a == REG_ADDR_LEN'(i));
  endfunction

  // x0 is never written, so regs[0] keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (addr_hit(wb_rd_enable, wb_rd_addr, i)) regs[i] <= wb_rd_data;
      end
    end
  end

  // Issue and retire to the same register cancel out; saturate at both ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        unique case ({addr_hit(issue_enable, issue_addr, i),
                      addr_hit(wb_rd_enable, wb_rd_addr, i)})
          2'b10:   if (cnt[i] != CNT_MAX)  cnt[i] <= cnt[i] + 1'b1;
          2'b01:   if (cnt[i] != CNT_ZERO) cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_comb begin
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    for (int i = 1; i < REG_NUM; i++) begin
      if (addr_hit(issue_enable, issue_addr, i) && !addr_hit(wb_rd_enable, wb_rd_addr, i)
          && cnt[i] == CNT_MAX)
        ovf_hit = 1'b1;
      if (addr_hit(wb_rd_enable, wb_rd_addr, i) && !addr_hit(issue_enable, issue_addr, i)
          && cnt[i] == CNT_ZERO)
        unf_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_overflow  <= 1'b0;
      sb_underflow <= 1'b0;
    end else begin
      if (ovf_hit) sb_overflow  <= 1'b1;
      if (unf_hit) sb_underflow <= 1'b1;
    end
  end

  assign ret1 = wb_rd_enable && (wb_rd_addr == read1_addr);
  assign ret2 = wb_rd_enable && (wb_rd_addr == read2_addr);

  // A same-cycle issue is deliberately ignored here: busy reflects older writes only.
  always_comb begin
    read1_data = '0;
    read1_busy = 1'b0;
    if (read1_enable && read1_addr != '0) begin
      read1_data = ret1 ? wb_rd_data : regs[read1_addr];
      read1_busy = (cnt[read1_addr] != CNT_W'(ret1));
    end
  end

  always_comb begin
    read2_data = '0;
    read2_busy = 1'b0;
    if (read2_enable && read2_addr != '0) begin
      read2_data = ret2 ? wb_rd_data : regs[read2_addr];
      read2_busy = (cnt[read2_addr] != CNT_W'(ret2));
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random legal traffic, all
// checked against an array-based model of registers and in-flight counts.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_rd_enable;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        read1_enable;
  logic [4:0]  read1_addr;
  logic [31:0] read1_data;
  logic        read1_busy;
  logic        read2_enable;
  logic [4:0]  read2_addr;
  logic [31:0] read2_data;
  logic        read2_busy;
  logic        issue_enable;
  logic [4:0]  issue_addr;
  logic        sb_overflow;
  logic        sb_underflow;

  int errors = 0;
  int checks = 0;

  logic [31:0] regs_m [32];
  int          cnt_m  [32];
  bit          ovf_m;
  bit          unf_m;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk          (clk),
    .rst          (rst),
    .wb_rd_enable (wb_rd_enable),
    .wb_rd_addr   (wb_rd_addr),
    .wb_rd_data   (wb_rd_data),
    .read1_enable (read1_enable),
    .read1_addr   (read1_addr),
    .read1_data   (read1_data),
    .read1_busy   (read1_busy),
    .read2_enable (read2_enable),
    .read2_addr   (read2_addr),
    .read2_data   (read2_data),
    .read2_busy   (read2_busy),
    .issue_enable (issue_enable),
    .issue_addr   (issue_addr),
    .sb_overflow  (sb_overflow),
    .sb_underflow (sb_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      regs_m[i] = '0;
      cnt_m[i]  = 0;
    end
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  function automatic logic [31:0] exp_data(input bit en, input int a);
    if (!en || a == 0) return '0;
    if (wb_rd_enable && int'(wb_rd_addr) == a) return wb_rd_data;
    return regs_m[a];
  endfunction

  function automatic logic exp_busy(input bit en, input int a);
    int ret;
    if (!en || a == 0) return 1'b0;
    ret = (wb_rd_enable && int'(wb_rd_addr) == a) ? 1 : 0;
    return (cnt_m[a] - ret) != 0;
  endfunction

  task automatic drive(input bit we, input int wa, input logic [31:0] wd,
                       input bit r1e, input int r1a, input bit r2e, input int r2a,
                       input bit ie, input int ia);
    wb_rd_enable = we;  wb_rd_addr = 5'(wa);  wb_rd_data = wd;
    read1_enable = r1e; read1_addr = 5'(r1a);
    read2_enable = r2e; read2_addr = 5'(r2a);
    issue_enable = ie;  issue_addr = 5'(ia);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd1"},  read1_data, exp_data(read1_enable, int'(read1_addr)));
    chk({tag, ".bsy1"}, 32'(read1_busy), 32'(exp_busy(read1_enable, int'(read1_addr))));
    chk({tag, ".rd2"},  read2_data, exp_data(read2_enable, int'(read2_addr)));
    chk({tag, ".bsy2"}, 32'(read2_busy), 32'(exp_busy(read2_enable, int'(read2_addr))));
    chk({tag, ".ovf"},  32'(sb_overflow),  32'(ovf_m));
    chk({tag, ".unf"},  32'(sb_underflow), 32'(unf_m));
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic step();
    int wa, ia;
    bit inc_any, dec_any;
    @(posedge clk);
    wa = int'(wb_rd_addr);
    ia = int'(issue_addr);
    inc_any = issue_enable && ia != 0;
    dec_any = wb_rd_enable && wa != 0;
    if (dec_any) regs_m[wa] = wb_rd_data;
    if (inc_any && dec_any && ia == wa) begin
      // cancels
    end else begin
      if (inc_any) begin
        if (cnt_m[ia] < 3) cnt_m[ia]++; else ovf_m = 1'b1;
      end
      if (dec_any) begin
        if (cnt_m[wa] > 0) cnt_m[wa]--; else unf_m = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset state over every register on both ports
    for (int a = 1; a < 32; a++) begin
      drive(0, 0, '0, 1, a, 1, 32 - a, 0, 0);
      chk("rst.rd1", read1_data, 32'h0);
      chk("rst.bsy1", 32'(read1_busy), 32'h0);
      check_all("rst");
    end
    chk("rst.ovf", 32'(sb_overflow), 32'h0);
    chk("rst.unf", 32'(sb_underflow), 32'h0);

    // Write then read; x0 write ignored
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 5); step();
    drive(0, 0, '0, 1, 5, 0, 0, 0, 0);
    chk("wr.x5", read1_data, 32'hDEADBEEF);
    check_all("wr"); step();
    drive(1, 0, 32'h1234, 1, 0, 1, 0, 0, 0);
    chk("wr.x0_byp", read1_data, 32'h0);
    check_all("x0w"); step();
    drive(0, 0, '0, 1, 0, 0, 0, 0, 0);
    chk("wr.x0", read1_data, 32'h0); step();

    // Bypass
    drive(1, 7, 32'hA5A5A5A5, 0, 0, 1, 7, 0, 0);
    chk("byp.x7", read2_data, 32'hA5A5A5A5);
    check_all("byp"); step();

    // Scoreboard: issue, busy, retire with bypass, clear
    drive(0, 0, '0, 1, 3, 0, 0, 1, 3);
    chk("sb.same_cyc", 32'(read1_busy), 32'h0);
    step();
    drive(0, 0, '0, 1, 3, 0, 0, 0, 0);
    chk("sb.busy", 32'(read1_busy), 32'h1); step();
    drive(1, 3, 32'h0BADF00D, 1, 3, 1, 3, 0, 0);
    chk("sb.ret_busy", 32'(read1_busy), 32'h0);
    chk("sb.ret_data", read2_data, 32'h0BADF00D);
    check_all("sbret"); step();
    drive(0, 0, '0, 1, 3, 0, 0, 0, 0);
    chk("sb.after", 32'(read1_busy), 32'h0); step();

    // Simultaneous issue/retire with cnt=1
    drive(0, 0, '0, 0, 0, 0, 0, 1, 4); step();
    drive(1, 4, 32'h44, 1, 4, 0, 0, 1, 4);
    chk("sim.busy_now", 32'(read1_busy), 32'h0);
    check_all("sim"); step();
    drive(0, 0, '0, 1, 4, 0, 0, 0, 0);
    chk("sim.busy_after", 32'(read1_busy), 32'h1); step();
    drive(1, 4, 32'h45, 0, 0, 0, 0, 0, 0); step();

    // Issue/retire on x0 must not disturb flags
    drive(1, 0, 32'h99, 0, 0, 0, 0, 1, 0); step();
    drive(1, 0, 32'h99, 0, 0, 0, 0, 1, 0); step();
    idle(); check_all("x0sb");

    // Random legal traffic on a small register window
    for (int n = 0; n < 400; n++) begin
      int wa, ia;
      bit we, ie;
      wa = $urandom_range(0, 7);
      ia = $urandom_range(0, 7);
      we = $urandom_range(0, 2) != 0 && (wa == 0 || cnt_m[wa] > 0);
      ie = $urandom_range(0, 1) != 0 && (ia == 0 || cnt_m[ia] < 3 || (we && wa == ia));
      drive(we, wa, $urandom, $urandom_range(0, 5) != 0, $urandom_range(0, 8),
            $urandom_range(0, 5) != 0, $urandom_range(0, 8), ie, ia);
      check_all("rnd");
      step();
    end

    // Asynchronous reset mid-operation clears state without a clock edge
    drive(0, 0, '0, 1, 5, 1, 3, 0, 0);
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst.rd1", read1_data, 32'h0);
    check_all("arst");
    rst = 1'b1;
    #1;
    step();

    // Overflow: four issues to x9
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, '0, 0, 0, 0, 0, 1, 9); step();
    end
    drive(0, 0, '0, 1, 9, 0, 0, 0, 0);
    chk("ovf.flag", 32'(sb_overflow), 32'h1);
    chk("ovf.busy", 32'(read1_busy), 32'h1);
    check_all("ovf");
    for (int k = 0; k < 3; k++) begin
      drive(1, 9, 32'(k), 1, 9, 0, 0, 0, 0); check_all("drain"); step();
    end
    drive(0, 0, '0, 1, 9, 0, 0, 0, 0);
    chk("ovf.drained", 32'(read1_busy), 32'h0);
    chk("ovf.no_unf", 32'(sb_underflow), 32'h0);

    // Underflow: retire x10 with nothing in flight
    drive(1, 10, 32'h10, 0, 0, 0, 0, 0, 0); step();
    idle();
    chk("unf.flag", 32'(sb_underflow), 32'h1);
    chk("unf.ovf_hold", 32'(sb_overflow), 32'h1);
    repeat (3) step();
    check_all("hold");

    rst = 1'b0;
    #1;
    model_reset();
    chk("clr.ovf", 32'(sb_overflow), 32'h0);
    chk("clr.unf", 32'(sb_underflow), 32'h0);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
